// File: rtl/pulse_receiver_pkg.sv
// Shared definitions for the pulse serial link: state encodings and default word width.
package pulse_receiver_pkg;

  localparam int PULSE_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } rx_state_e;

endpackage

// File: rtl/frame_bit_counter.sv
// Loadable up-counter that flags when the count reaches a fixed terminal value.
module frame_bit_counter #(
  parameter int               CNT_W    = 5,
  parameter logic [CNT_W-1:0] TERMINAL = '1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             inc,
  output logic             terminal
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == TERMINAL);

endmodule

// File: rtl/pulse_receiver.sv
// Serial-to-parallel receiver for the pulse link; assembles WIDTH-bit words framed by frame_start.
// Build option: define PULSE_RX_PARITY_CHECK_EN to expect a trailing even-parity bit per frame.
module pulse_receiver
  import pulse_receiver_pkg::*;
#(
  parameter int WIDTH     = PULSE_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             serial_in,
  input  logic             frame_start,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             frame_error,
  output logic             parity_error,
  output logic [1:0]       debug_state
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  rx_state_e        state, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next, first_word, word_out;
  logic             last_bit;
  logic             start_frame, shift_en, deliver, abort;

  frame_bit_counter #(
    .CNT_W   (CNT_W),
    .TERMINAL(LAST_BIT)
  ) u_bit_counter (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (start_frame),
    .load_value(ONE),
    .inc       (shift_en),
    .terminal  (last_bit)
  );

  // First bit of a frame lands at the end of the register that shifting moves away from.
  always_comb begin
    first_word = '0;
    if (MSB_FIRST) begin
      first_word[0] = serial_in;
      shift_next    = {shift_reg[WIDTH-2:0], serial_in};
    end else begin
      first_word[WIDTH-1] = serial_in;
      shift_next          = {serial_in, shift_reg[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    shift_en    = 1'b0;
    deliver     = 1'b0;
    abort       = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) begin
          start_frame = 1'b1;
          state_next  = SHIFT;
        end
      end
      SHIFT: begin
        if (frame_start) begin
          abort       = 1'b1;
          start_frame = 1'b1;
          state_next  = SHIFT;
        end else begin
          shift_en = 1'b1;
          if (last_bit) begin
`ifdef PULSE_RX_PARITY_CHECK_EN
            state_next = PARITY;
`else
            deliver    = 1'b1;
            state_next = IDLE;
`endif
          end
        end
      end
`ifdef PULSE_RX_PARITY_CHECK_EN
      PARITY: begin
        if (frame_start) begin
          abort       = 1'b1;
          start_frame = 1'b1;
          state_next  = SHIFT;
        end else begin
          deliver    = 1'b1;
          state_next = IDLE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

`ifdef PULSE_RX_PARITY_CHECK_EN
  assign word_out = shift_reg;
`else
  assign word_out = shift_next;
`endif

  // data_valid is a one-cycle pulse with no ready: the consumer must capture data_out that cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg   <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      data_valid  <= deliver;
      frame_error <= abort;
      if (start_frame)   shift_reg <= first_word;
      else if (shift_en) shift_reg <= shift_next;
      if (deliver)       data_out  <= word_out;
    end
  end

`ifdef PULSE_RX_PARITY_CHECK_EN
  // Even parity: data bits XOR parity bit is 1 only when the frame is corrupt.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) parity_error <= 1'b0;
    else          parity_error <= deliver & ((^shift_reg) ^ serial_in);
  end
`else
  assign parity_error = 1'b0;
`endif

  assign busy        = (state != IDLE);
  assign debug_state = state;

endmodule

// File: tb/tb_pulse_receiver.sv
// Directed bench for pulse_receiver: one MSB-first and one LSB-first instance on a shared serial line.
module tb_pulse_receiver;
  import pulse_receiver_pkg::*;

  localparam int W = 16;
`ifdef PULSE_RX_PARITY_CHECK_EN
  localparam int NBITS = W + 1;
`else
  localparam int NBITS = W;
`endif

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         serial_in = 1'b0;
  logic         frame_start = 1'b0;

  logic [W-1:0] data_out, l_data_out;
  logic         data_valid, busy, frame_error, parity_error;
  logic         l_data_valid, l_busy, l_frame_error, l_parity_error;
  logic [1:0]   debug_state, l_debug_state;

  int n_pass = 0;
  int n_total = 0;

  pulse_receiver #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clock       (clock),
    .reset_n     (reset_n),
    .serial_in   (serial_in),
    .frame_start (frame_start),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .busy        (busy),
    .frame_error (frame_error),
    .parity_error(parity_error),
    .debug_state (debug_state)
  );

  pulse_receiver #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clock       (clock),
    .reset_n     (reset_n),
    .serial_in   (serial_in),
    .frame_start (frame_start),
    .data_out    (l_data_out),
    .data_valid  (l_data_valid),
    .busy        (l_busy),
    .frame_error (l_frame_error),
    .parity_error(l_parity_error),
    .debug_state (l_debug_state)
  );

  // Clock / reset block
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drives one frame, one bit per negedge; checks the in-frame outputs on the way.
  task automatic send_frame(input logic [W-1:0] word, input bit b2b, input logic [W-1:0] hold_word,
                            input bit pbit, input bit abort_exp);
    for (int i = 0; i < NBITS; i++) begin
      @(negedge clock);
      if (i == 0 && b2b) begin
        check("b2b_valid", data_valid, 1'b1);
        check("b2b_data", data_out, hold_word);
        check("b2b_no_ferr", frame_error, 1'b0);
      end
      if (i > 0) begin
        check("frame_valid_low", data_valid, 1'b0);
        check("frame_busy", busy, 1'b1);
        check("frame_ferr", frame_error, (i == 1) && abort_exp);
        check("frame_hold", data_out, hold_word);
      end
      frame_start = (i == 0);
      if (i < W) serial_in = word[W-1-i];
      else       serial_in = pbit;
    end
  endtask

  task automatic check_word(input logic [W-1:0] exp, input bit exp_perr);
    @(negedge clock);
    frame_start = 1'b0;
    serial_in   = 1'b0;
    check("word_valid", data_valid, 1'b1);
    check("word_data", data_out, exp);
    check("word_busy_low", busy, 1'b0);
    check("word_ferr", frame_error, 1'b0);
    check("word_perr", parity_error, exp_perr);
    check("word_state", debug_state, 2'd0);
    @(negedge clock);
    check("post_valid_low", data_valid, 1'b0);
    check("post_perr_low", parity_error, 1'b0);
    check("post_data_held", data_out, exp);
  endtask

  initial begin
    #2;
    check("rst_data", data_out, 16'h0000);
    check("rst_valid", data_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ferr", frame_error, 1'b0);
    check("rst_perr", parity_error, 1'b0);
    check("rst_state", debug_state, 2'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Single frame, latency and bit order on both instances
    send_frame(16'hA5C3, 1'b0, 16'h0000, ^16'hA5C3, 1'b0);
    check_word(16'hA5C3, 1'b0);
    check("lsb_reversed", l_data_out, 16'hC3A5);

    // Back-to-back frames
    send_frame(16'hFFFF, 1'b0, 16'hA5C3, ^16'hFFFF, 1'b0);
    send_frame(16'h0001, 1'b1, 16'hFFFF, ^16'h0001, 1'b0);
    check_word(16'h0001, 1'b0);

    // Abort after 5 bits, then a full frame
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      frame_start = (k == 0);
      serial_in   = 1'($urandom_range(0, 1));
    end
    send_frame(16'h5A5A, 1'b0, 16'h0001, ^16'h5A5A, 1'b1);
    check_word(16'h5A5A, 1'b0);

    // frame_start held high: every edge after the first aborts
    @(negedge clock);
    frame_start = 1'b1;
    serial_in   = 1'b0;
    @(negedge clock);
    check("hold_first_no_ferr", frame_error, 1'b0);
    check("hold_busy", busy, 1'b1);
    @(negedge clock);
    check("hold_ferr_1", frame_error, 1'b1);
    @(negedge clock);
    check("hold_ferr_2", frame_error, 1'b1);
    check("hold_no_valid", data_valid, 1'b0);
    check("hold_data_kept", data_out, 16'h5A5A);
    frame_start = 1'b0;

    // Reset mid-frame
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      serial_in = 1'($urandom_range(0, 1));
    end
    @(negedge clock);
    check("midframe_busy", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    check("midrst_data", data_out, 16'h0000);
    check("midrst_lsb_data", l_data_out, 16'h0000);
    check("midrst_busy", busy, 1'b0);
    check("midrst_valid", data_valid, 1'b0);
    check("midrst_ferr", frame_error, 1'b0);
    check("midrst_state", debug_state, 2'd0);
    @(negedge clock);
    reset_n = 1'b1;
    send_frame(16'h1234, 1'b0, 16'h0000, ^16'h1234, 1'b0);
    check_word(16'h1234, 1'b0);

    // Stream 1,0,0,...: LSB-first instance sees 0x0001
    send_frame(16'h8000, 1'b0, 16'h1234, ^16'h8000, 1'b0);
    check_word(16'h8000, 1'b0);
    check("lsb_first_bit0", l_data_out, 16'h0001);

`ifdef PULSE_RX_PARITY_CHECK_EN
    send_frame(16'h0003, 1'b0, 16'h8000, 1'b0, 1'b0);
    check_word(16'h0003, 1'b0);
    send_frame(16'h0007, 1'b0, 16'h0003, 1'b0, 1'b0);
    check_word(16'h0007, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
